// File: rtl/axis_write_arb.sv
`default_nettype none
// ============================================================================
// Module   : axis_write_arb
// Purpose  : Round-robin AXI write-address arbiter that splits per-channel
//            transfers into 4 KB-safe bursts and issues AW + data-mover cmds.
// Revision : 1.0
// ============================================================================
module axis_write_arb #(
    parameter int CHANNELS        = 4,
    parameter int CFG_AWIDTH      = 5,
    parameter int CFG_DWIDTH      = 32,
    parameter int CFG_ADDR_BASE   = 8,
    parameter int CFG_LEN_BASE    = 16,
    parameter int CFG_ERR_CLR     = 31,
    parameter int AXI_LEN_WIDTH   = 8,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int BURST_LEN       = 16,
    parameter int MAX_OUTSTANDING = 8,
    localparam int CHW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CFG_AWIDTH-1:0]     cfg_addr,
    input  logic [CFG_DWIDTH-1:0]     cfg_data,
    input  logic                      cfg_valid,
    input  logic [CHANNELS-1:0]       ch_avail,
    output logic [CHANNELS-1:0]       ch_busy,
    input  logic                      axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
    output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
    output logic                      axi_awvalid,
    input  logic [1:0]                axi_bresp,
    input  logic                      axi_bvalid,
    output logic                      axi_bready,
    output logic                      cmd_valid,
    output logic [CHW-1:0]            cmd_ch,
    output logic [AXI_LEN_WIDTH-1:0]  cmd_len,
    input  logic                      cmd_ready,
    output logic                      err,
    output logic                      idle
);

    localparam int c_ABITS = $clog2(AXI_DATA_WIDTH / 8);
    localparam int c_OW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] c_ADDR_MASK =
        ~AXI_ADDR_WIDTH'((1 << c_ABITS) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t                    r_state, w_next;
    logic [AXI_ADDR_WIDTH-1:0] r_addr [CHANNELS];
    logic [CFG_DWIDTH-1:0]     r_rem  [CHANNELS];
    logic [CHANNELS-1:0]       r_busy;
    logic [c_OW-1:0]           r_outst;
    logic [CHW-1:0]            r_rr_ptr;
    logic                      r_err;
    logic                      r_awvalid, r_cmd_valid;
    logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
    logic [AXI_LEN_WIDTH-1:0]  r_len;
    logic [CHW-1:0]            r_cmd_ch;
    logic [CFG_DWIDTH-1:0]     r_beats;

    logic [CHANNELS-1:0]       w_elig;
    logic                      w_found;
    logic [CHW-1:0]            w_grant;
    logic [CHW-1:0]            w_rr_next;
    int                        w_idx;
    logic [12:0]               w_to4k;
    logic [12:0]               w_to4k_beats;
    logic [CFG_DWIDTH-1:0]     w_beats;
    logic                      w_arb_go, w_issue_done, w_aw_hs, w_b_hs;

    assign w_elig = (r_outst < c_OW'(MAX_OUTSTANDING)) ? (r_busy & ch_avail) : '0;

    // Round-robin search starting at the channel after the last grant.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= CHANNELS) w_idx = w_idx - CHANNELS;
            if (!w_found && w_elig[CHW'(w_idx)]) begin
                w_found = 1'b1;
                w_grant = CHW'(w_idx);
            end
        end
    end

    assign w_rr_next = (int'(w_grant) == CHANNELS - 1) ? '0 : w_grant + CHW'(1);

    // Burst size: smallest of remaining, max burst, and beats left in the 4 KB page.
    always_comb begin
        w_to4k       = 13'h1000 - {1'b0, r_addr[w_grant][11:0]};
        w_to4k_beats = w_to4k >> c_ABITS;
        w_beats      = CFG_DWIDTH'(BURST_LEN);
        if (CFG_DWIDTH'(w_to4k_beats) < w_beats) w_beats = CFG_DWIDTH'(w_to4k_beats);
        if (r_rem[w_grant] < w_beats)            w_beats = r_rem[w_grant];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (|w_elig) w_next = S_ARB;
            S_ARB:   w_next = w_found ? S_ISSUE : S_IDLE;
            S_ISSUE: if (!r_awvalid && !r_cmd_valid) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_arb_go     = (r_state == S_ARB) && w_found;
    assign w_issue_done = (r_state == S_ISSUE) && !r_awvalid && !r_cmd_valid;
    assign w_aw_hs      = r_awvalid && axi_awready;
    assign w_b_hs       = axi_bvalid && (r_outst != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awvalid   <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_awaddr    <= '0;
            r_len       <= '0;
            r_cmd_ch    <= '0;
            r_beats     <= '0;
            r_rr_ptr    <= '0;
        end else if (w_arb_go) begin
            r_awvalid   <= 1'b1;
            r_cmd_valid <= 1'b1;
            r_awaddr    <= r_addr[w_grant];
            r_len       <= AXI_LEN_WIDTH'(w_beats - CFG_DWIDTH'(1));
            r_cmd_ch    <= w_grant;
            r_beats     <= w_beats;
            r_rr_ptr    <= w_rr_next;
        end else begin
            if (w_aw_hs)                 r_awvalid   <= 1'b0;
            if (r_cmd_valid && cmd_ready) r_cmd_valid <= 1'b0;
        end
    end

    // Busy channels are locked against reconfiguration; the issuing channel is always busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_addr[ch] <= '0;
                r_rem[ch]  <= '0;
            end
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (w_issue_done && (r_cmd_ch == CHW'(ch))) begin
                    r_addr[ch] <= r_addr[ch] + AXI_ADDR_WIDTH'(r_beats << c_ABITS);
                    r_rem[ch]  <= r_rem[ch] - r_beats;
                    if (r_rem[ch] == r_beats) r_busy[ch] <= 1'b0;
                end else if (cfg_valid && !r_busy[ch]) begin
                    if (cfg_addr == CFG_AWIDTH'(CFG_ADDR_BASE + ch))
                        r_addr[ch] <= AXI_ADDR_WIDTH'(cfg_data) & c_ADDR_MASK;
                    if ((cfg_addr == CFG_AWIDTH'(CFG_LEN_BASE + ch)) && (cfg_data != '0)) begin
                        r_rem[ch]  <= cfg_data;
                        r_busy[ch] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outst <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_aw_hs && !w_b_hs)      r_outst <= r_outst + c_OW'(1);
            else if (!w_aw_hs && w_b_hs) r_outst <= r_outst - c_OW'(1);
            if (axi_bvalid && (axi_bresp != 2'b00))
                r_err <= 1'b1;
            else if (cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_ERR_CLR)))
                r_err <= 1'b0;
        end
    end

    assign ch_busy     = r_busy;
    assign axi_awaddr  = r_awaddr;
    assign axi_awlen   = r_len;
    assign axi_awvalid = r_awvalid;
    assign axi_bready  = 1'b1;
    assign cmd_valid   = r_cmd_valid;
    assign cmd_ch      = r_cmd_ch;
    assign cmd_len     = r_len;
    assign err         = r_err;
    assign idle        = ~|r_busy && (r_outst == '0);

endmodule
`default_nettype wire
